// File: rtl/mfp_eic_priority_scheduler.sv
// Sequential EIC priority resolver: sweeps one channel per clock, presents the highest-priority
// pending request as SI_Int/SI_EICVector and issues a pending-clear on acknowledge.
module mfp_eic_priority_scheduler #(
   parameter int unsigned CHANNELS = 16,
   parameter int unsigned PRIO_W   = 4,
   parameter int unsigned IDX_W    = 6
) (
   input  logic                       CLK,
   input  logic                       RESETn,
   input  logic [CHANNELS-1:0]        pending,
   input  logic [CHANNELS-1:0]        enable,
   input  logic [CHANNELS*PRIO_W-1:0] prio,
   input  logic                       EIC_IAck,
   output logic [7:0]                 EIC_Interrupt,
   output logic [5:0]                 EIC_Vector,
   output logic                       clr_valid,
   output logic [IDX_W-1:0]           clr_channel,
   output logic                       spurious_ack,
   output logic                       sweep_done
);

   typedef enum logic [0:0] {StScan, StDrain} state_e;

   localparam int unsigned      NumIdx  = 2 ** IDX_W;
   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(CHANNELS - 1);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [IDX_W-1:0]  best_idx_q, best_idx_d;
   logic [PRIO_W-1:0] best_prio_q, best_prio_d;
   logic [PRIO_W-1:0] int_q, int_d;
   logic [5:0]        vec_q, vec_d;
   logic              clr_valid_q, clr_valid_d;
   logic [IDX_W-1:0]  clr_channel_q, clr_channel_d;
   logic              spurious_q, spurious_d;

   logic [NumIdx-1:0] req_ext;
   logic [PRIO_W-1:0] prio_ext [NumIdx];
   logic [PRIO_W-1:0] cur_prio;
   logic [PRIO_W-1:0] win_prio;
   logic [IDX_W-1:0]  win_idx;
   logic              cand;
   logic              ack_valid;

   // Pad channel state out to the full index range so idx_q selects without width games.
   always_comb begin
      for (int unsigned i = 0; i < NumIdx; i++) begin
         req_ext[i]  = 1'b0;
         prio_ext[i] = '0;
      end
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         req_ext[i]  = pending[i] & enable[i];
         prio_ext[i] = prio[i*PRIO_W +: PRIO_W];
      end
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      best_prio_d   = best_prio_q;
      best_idx_d    = best_idx_q;
      int_d         = int_q;
      vec_d         = vec_q;
      clr_valid_d   = 1'b0;
      clr_channel_d = clr_channel_q;
      spurious_d    = 1'b0;

      cur_prio  = prio_ext[idx_q];
      cand      = req_ext[idx_q] && (cur_prio != '0);
      ack_valid = (state_q == StScan) && EIC_IAck && (int_q != '0);

      // Strictly-greater replacement keeps ties on the lowest index.
      win_prio = best_prio_q;
      win_idx  = best_idx_q;
      if (cand && (cur_prio > best_prio_q)) begin
         win_prio = cur_prio;
         win_idx  = idx_q;
      end

      unique case (state_q)
         StScan: begin
            if (ack_valid) begin
               clr_valid_d   = 1'b1;
               clr_channel_d = IDX_W'(vec_q);
               int_d         = '0;
               idx_d         = '0;
               best_prio_d   = '0;
               best_idx_d    = '0;
               state_d       = StDrain;
            end else begin
               spurious_d = EIC_IAck;
               if (idx_q == LastIdx) begin
                  int_d       = win_prio;
                  if (win_prio != '0) vec_d = 6'(win_idx);
                  idx_d       = '0;
                  best_prio_d = '0;
                  best_idx_d  = '0;
               end else begin
                  idx_d       = idx_q + IDX_W'(1);
                  best_prio_d = win_prio;
                  best_idx_d  = win_idx;
               end
            end
         end
         StDrain: begin
            spurious_d = EIC_IAck;
            idx_d      = '0;
            state_d    = StScan;
         end
         default: state_d = StScan;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q       <= StScan;
         idx_q         <= '0;
         best_idx_q    <= '0;
         best_prio_q   <= '0;
         int_q         <= '0;
         vec_q         <= '0;
         clr_valid_q   <= 1'b0;
         clr_channel_q <= '0;
         spurious_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         best_idx_q    <= best_idx_d;
         best_prio_q   <= best_prio_d;
         int_q         <= int_d;
         vec_q         <= vec_d;
         clr_valid_q   <= clr_valid_d;
         clr_channel_q <= clr_channel_d;
         spurious_q    <= spurious_d;
      end
   end

   assign EIC_Interrupt = 8'(int_q);
   assign EIC_Vector    = vec_q;
   assign clr_valid     = clr_valid_q;
   assign clr_channel   = clr_channel_q;
   assign spurious_ack  = spurious_q;
   assign sweep_done    = (state_q == StScan) && (idx_q == LastIdx);

endmodule

// File: tb/tb_mfp_eic_priority_scheduler.sv
// Randomized + directed bench for mfp_eic_priority_scheduler with a sweep-level reference model
// feeding event queues that an independent monitor drains.
module tb_mfp_eic_priority_scheduler;

   localparam int C  = 16;
   localparam int PW = 4;
   localparam int IW = 6;

   logic            CLK = 1'b0;
   logic            RESETn = 1'b0;
   logic [C-1:0]    pending;
   logic [C-1:0]    enable;
   logic [C*PW-1:0] prio;
   logic            EIC_IAck;
   logic [7:0]      EIC_Interrupt;
   logic [5:0]      EIC_Vector;
   logic            clr_valid;
   logic [IW-1:0]   clr_channel;
   logic            spurious_ack;
   logic            sweep_done;

   int total = 0;
   int bad   = 0;
   bit autoclr = 0;

   always #5 CLK = ~CLK;

   mfp_eic_priority_scheduler #(
      .CHANNELS(C),
      .PRIO_W  (PW),
      .IDX_W   (IW)
   ) dut (
      .CLK          (CLK),
      .RESETn       (RESETn),
      .pending      (pending),
      .enable       (enable),
      .prio         (prio),
      .EIC_IAck     (EIC_IAck),
      .EIC_Interrupt(EIC_Interrupt),
      .EIC_Vector   (EIC_Vector),
      .clr_valid    (clr_valid),
      .clr_channel  (clr_channel),
      .spurious_ack (spurious_ack),
      .sweep_done   (sweep_done)
   );

   // Expected-event queues filled by the model, drained by the monitor.
   int q_int[$];
   int q_vec[$];
   int q_clr[$];
   int q_spur[$];

   int m_pos;
   bit m_drain;
   int m_int;
   int m_vec;
   bit m_sd;
   bit snap_r[C];
   int snap_p[C];

   task automatic check(string name, int got, int want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
      end
   endtask

   function automatic int prio_of(int ch);
      return int'(prio[ch*PW +: PW]);
   endfunction

   task automatic model_reset();
      m_pos = 0; m_drain = 0; m_int = 0; m_vec = 0; m_sd = 0;
      q_int.delete(); q_vec.delete(); q_clr.delete(); q_spur.delete();
   endtask

   // One clock of the reference: snapshot each channel at its slot, pick the winner at sweep end.
   task automatic model_step();
      bit ack;
      int maxp;
      bit found;
      ack = EIC_IAck;
      if (m_drain) begin
         if (ack) q_spur.push_back(1);
         m_drain = 0;
         m_pos   = 0;
      end else if (ack && m_int != 0) begin
         q_clr.push_back(m_vec);
         m_int   = 0;
         m_pos   = 0;
         m_drain = 1;
      end else begin
         if (ack) q_spur.push_back(1);
         snap_r[m_pos] = pending[m_pos] && enable[m_pos] && (prio_of(m_pos) != 0);
         snap_p[m_pos] = prio_of(m_pos);
         if (m_pos == C - 1) begin
            maxp = 0;
            for (int i = 0; i < C; i++) if (snap_r[i] && snap_p[i] > maxp) maxp = snap_p[i];
            found = 0;
            for (int i = 0; i < C; i++) begin
               if (!found && maxp != 0 && snap_r[i] && snap_p[i] == maxp) begin
                  m_vec = i;
                  found = 1;
               end
            end
            m_int = maxp;
            q_int.push_back(m_int);
            q_vec.push_back(m_vec);
            m_pos = 0;
         end else begin
            m_pos++;
         end
      end
      m_sd = !m_drain && (m_pos == C - 1);
   endtask

   initial begin
      forever begin
         @(posedge CLK);
         if (!RESETn) model_reset();
         else model_step();
      end
   end

   // Monitor: reacts to DUT output events and compares against queued expectations.
   bit commit_due = 0;
   initial begin
      forever begin
         @(negedge CLK);
         if (!RESETn) begin
            commit_due = 0;
         end else begin
            if (commit_due) begin
               commit_due = 0;
               if (q_int.size() == 0) check("commit_unexpected", 1, 0);
               else begin
                  check("commit_int", int'(EIC_Interrupt), q_int.pop_front());
                  check("commit_vec", int'(EIC_Vector), q_vec.pop_front());
               end
            end
            check("sweep_done_timing", int'(sweep_done), int'(m_sd));
            if (sweep_done && !(EIC_IAck && EIC_Interrupt != 0)) commit_due = 1;
            if (clr_valid) begin
               if (q_clr.size() == 0) check("clr_unexpected", 1, 0);
               else begin
                  check("clr_channel", int'(clr_channel), q_clr.pop_front());
                  check("clr_int_zero", int'(EIC_Interrupt), 0);
                  check("clr_no_spur", int'(spurious_ack), 0);
               end
            end
            if (spurious_ack) begin
               if (q_spur.size() == 0) check("spur_unexpected", 1, 0);
               else begin
                  void'(q_spur.pop_front());
                  check("spur_no_clr", int'(clr_valid), 0);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
      if (autoclr && clr_valid) pending[clr_channel] = 1'b0;
   endtask

   task automatic set_prio(int ch, int v);
      prio[ch*PW +: PW] = PW'(v);
   endtask

   task automatic wait_int(string name, int want, int maxc);
      int n;
      n = 0;
      while (int'(EIC_Interrupt) != want && n < maxc) begin
         tick();
         n++;
      end
      check(name, int'(EIC_Interrupt), want);
   endtask

   task automatic pulse_ack();
      EIC_IAck = 1'b1;
      tick();
      EIC_IAck = 1'b0;
   endtask

   initial begin
      int n;
      pending  = '1;
      enable   = '1;
      EIC_IAck = 1'b0;
      for (int i = 0; i < C; i++) set_prio(i, (i % 15) + 1);
      repeat (3) tick();
      RESETn = 1'b1;
      repeat (2 * C + 5) tick();
      check("all_on_int", int'(EIC_Interrupt), 15);
      check("all_on_vec", int'(EIC_Vector), 14);

      // Asynchronous reset in the middle of a sweep.
      RESETn = 1'b0;
      #1;
      check("rst_int", int'(EIC_Interrupt), 0);
      check("rst_vec", int'(EIC_Vector), 0);
      check("rst_clr", int'(clr_valid), 0);
      check("rst_clr_ch", int'(clr_channel), 0);
      check("rst_spur", int'(spurious_ack), 0);
      check("rst_sweep", int'(sweep_done), 0);
      tick();
      tick();
      RESETn = 1'b1;
      repeat (C - 2) tick();
      check("pre_sweep_done", int'(sweep_done), 0);
      tick();
      check("first_sweep_done", int'(sweep_done), 1);
      check("pre_commit_int", int'(EIC_Interrupt), 0);
      tick();
      check("first_commit_int", int'(EIC_Interrupt), 15);

      // Single request, then masked.
      pending = '0; enable = '0; prio = '0;
      pending[5] = 1'b1; enable[5] = 1'b1; set_prio(5, 3);
      wait_int("single_int", 3, 2 * C + 2);
      check("single_vec", int'(EIC_Vector), 5);
      enable[5] = 1'b0;
      repeat (2 * C + 2) tick();
      check("masked_int", int'(EIC_Interrupt), 0);

      // Priority and tie-break.
      pending = '0; enable = '0; prio = '0;
      pending[2] = 1'b1; pending[7] = 1'b1; pending[9] = 1'b1;
      enable[2] = 1'b1; enable[7] = 1'b1; enable[9] = 1'b1;
      set_prio(2, 4); set_prio(7, 6); set_prio(9, 6);
      repeat (2 * C + 2) tick();
      check("tie_vec", int'(EIC_Vector), 7);
      check("tie_int", int'(EIC_Interrupt), 6);
      pending[7] = 1'b0;
      repeat (2 * C + 2) tick();
      check("tie2_vec", int'(EIC_Vector), 9);
      pending[9] = 1'b0;
      repeat (2 * C + 2) tick();
      check("low_vec", int'(EIC_Vector), 2);
      check("low_int", int'(EIC_Interrupt), 4);

      // Acknowledge, DRAIN, sweep restart.
      pending[7] = 1'b1;
      repeat (2 * C + 2) tick();
      check("ack_pre_vec", int'(EIC_Vector), 7);
      autoclr = 1;
      pulse_ack();
      check("ack_clr", int'(clr_valid), 1);
      check("ack_clr_ch", int'(clr_channel), 7);
      check("ack_int", int'(EIC_Interrupt), 0);
      tick();
      check("drain_clr", int'(clr_valid), 0);
      repeat (C - 1) tick();
      check("restart_sweep", int'(sweep_done), 1);

      // IAck coincident with the last index: commit dropped, clear issued.
      tick();
      check("reload_int", int'(EIC_Interrupt), 4);
      n = 0;
      while (!sweep_done && n < C + 2) begin
         tick();
         n++;
      end
      check("coinc_sweep", int'(sweep_done), 1);
      pulse_ack();
      check("coinc_clr", int'(clr_valid), 1);
      check("coinc_clr_ch", int'(clr_channel), 2);
      check("coinc_int", int'(EIC_Interrupt), 0);

      // Preemption.
      autoclr = 0;
      pending = '0; enable = '0; prio = '0;
      pending[3] = 1'b1; enable[3] = 1'b1; set_prio(3, 2);
      wait_int("pre_low_int", 2, 2 * C + 2);
      check("pre_low_vec", int'(EIC_Vector), 3);
      pending[12] = 1'b1; enable[12] = 1'b1; set_prio(12, 5);
      wait_int("preempt_int", 5, 2 * C + 2);
      check("preempt_vec", int'(EIC_Vector), 12);

      // Spurious acknowledges.
      pending = '0;
      repeat (2 * C + 2) tick();
      check("idle_int", int'(EIC_Interrupt), 0);
      pulse_ack();
      check("spur_idle", int'(spurious_ack), 1);
      check("spur_idle_clr", int'(clr_valid), 0);
      pending[3] = 1'b1;
      wait_int("spur_pre_int", 2, 2 * C + 2);
      autoclr  = 1;
      EIC_IAck = 1'b1;
      tick();
      check("spur_ack_clr", int'(clr_valid), 1);
      tick();
      EIC_IAck = 1'b0;
      check("spur_drain", int'(spurious_ack), 1);
      check("spur_drain_clr", int'(clr_valid), 0);
      repeat (C - 1) tick();
      check("spur_drain_len", int'(sweep_done), 1);

      // Random traffic against the model.
      enable = '1;
      for (int k = 0; k < 2000; k++) begin
         tick();
         if ($urandom_range(0, 3) == 0) pending[$urandom_range(0, C - 1)] = 1'b1;
         if ($urandom_range(0, 63) == 0) enable = C'($urandom);
         if ($urandom_range(0, 3) == 0) set_prio($urandom_range(0, C - 1), $urandom_range(0, 15));
         EIC_IAck = ($urandom_range(0, 15) == 0);
      end
      EIC_IAck = 1'b0;
      repeat (2) tick();
      @(negedge CLK);
      #1;
      check("left_clr", q_clr.size(), 0);
      check("left_spur", q_spur.size(), 0);
      check("left_commit", q_int.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
